// File: rtl/per_bus_pkg.sv
// Shared types and helpers for masters on the 16-bit peripheral bus.
package per_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] PER_WE_READ = 2'b00;
    localparam logic [1:0] PER_WE_WORD = 2'b11;

    typedef logic [13:0] per_addr_t;

    // Row-major element address; wraps silently modulo 2^14.
    function automatic per_addr_t elem_addr(input per_addr_t base, input int unsigned row,
                                            input int unsigned col, input int unsigned n);
        return per_addr_t'(32'(base) + row * n + col);
    endfunction

endpackage

// File: rtl/per_idx_counter.sv
// Nested row/column index counter over an N x N element grid, row-major order.
module per_idx_counter #(
    parameter int N = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] r,
    output logic [CW-1:0] c,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(N - 1);

    assign last = (r == MAX) && (c == MAX);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r <= '0;
            c <= '0;
        end else if (clr) begin
            r <= '0;
            c <= '0;
        end else if (inc) begin
            if (c == MAX) begin
                c <= '0;
                r <= (r == MAX) ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

endmodule

// File: rtl/per_transpose_master.sv
// Peripheral-bus master: reads an N x N word matrix row-major and writes it
// back transposed, one bus cycle per clock, alternating read/write.
module per_transpose_master
    import per_bus_pkg::*;
#(
    parameter int        N        = 4,
    parameter per_addr_t SRC_BASE = 14'h088,
    parameter per_addr_t DST_BASE = 14'h090
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] MAX = CW'(N - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] r, c, r_next, c_next;
    logic          last, cnt_clr, cnt_inc;
    logic [15:0]   hold_reg, hold_next;
    per_addr_t     addr_next;
    logic          en_next, busy_next, done_next;
    logic [1:0]    we_next;

    per_idx_counter #(.N(N)) u_idx (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .r       (r),
        .c       (c),
        .last    (last)
    );

    // hold is only non-zero during WR, so it doubles as the registered write data.
    assign per_din = hold_reg;

    // Coordinates the counter will hold after the next increment; needed so the
    // following RD address can be registered at the same edge.
    always_comb begin
        r_next = r;
        c_next = c + 1'b1;
        if (c == MAX) begin
            c_next = '0;
            r_next = r + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = '0;
        en_next    = 1'b0;
        we_next    = PER_WE_READ;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        hold_next  = '0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RD;
                    cnt_clr    = 1'b1;
                    en_next    = 1'b1;
                    busy_next  = 1'b1;
                    addr_next  = SRC_BASE;
                end
            end
            RD: begin
                state_next = WR;
                en_next    = 1'b1;
                we_next    = PER_WE_WORD;
                busy_next  = 1'b1;
                hold_next  = per_dout;
                addr_next  = elem_addr(DST_BASE, 32'(c), 32'(r), N);
            end
            WR: begin
                if (last) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = RD;
                    cnt_inc    = 1'b1;
                    en_next    = 1'b1;
                    busy_next  = 1'b1;
                    addr_next  = elem_addr(SRC_BASE, 32'(r_next), 32'(c_next), N);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            per_addr  <= '0;
            per_en    <= 1'b0;
            per_we    <= PER_WE_READ;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            per_addr  <= addr_next;
            per_en    <= en_next;
            per_we    <= we_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: doc/per_transpose_master.md
# per_transpose_master

Bus initiator for the 16-bit openMSP430-style peripheral bus: on a start pulse it reads an N×N word matrix from one peripheral word-address window and writes it back transposed into a second window. It sits on the master side of the same per_addr/per_din/per_en/per_we/per_dout bus that the memory-mapped register slaves respond to. Its purpose is to move the transpose work off software in the matrix-transpose datapath.

## Interface
- N, 4: matrix dimension, legal range 1..16.
- SRC_BASE, 14'h088: word address of source element (0,0), row-major.
- DST_BASE, 14'h090: word address of destination element (0,0), row-major.
- mclk  in  1  system clock.
- puc_rst  in  1  power-up clear. Asynchronous, active-high; clock is mclk.
- start  in  1  single-cycle request, sampled only in IDLE.
- busy  out  1  high from the first bus cycle through the last write.
- done  out  1  one-cycle pulse after the last write.
- per_addr  out  14  word address driven to slaves.
- per_din  out  16  write data driven to slaves.
- per_en  out  1  active bus cycle.
- per_we  out  2  byte write enables: 2'b00 = read, 2'b11 = word write.
- per_dout  in  16  read data from slaves, valid combinationally in the same cycle as the read.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE: all bus outputs 0, busy=0. start=1 clears row counter r and column counter c, then goes to RD.
- RD: per_en=1, per_we=2'b00, per_addr = SRC_BASE + r*N + c. per_dout is captured into a 16-bit hold register at the end of the cycle. Next state is WR.
- WR: per_en=1, per_we=2'b11, per_addr = DST_BASE + c*N + r, per_din = hold.
  - If c<N-1: c increments and next state is RD.
  - Else if r<N-1: c clears, r increments, next state is RD.
  - Else next state is DONE.
- DONE: bus outputs 0, busy=0, done=1 for one cycle, then IDLE.
- Order of traversal: source row-major; destination is column-major, i.e. element (r,c) lands at (c,r).
- Diagonal elements are rewritten at the mirrored address like any other element; there is no special case.
- Address arithmetic is 14-bit, modulo 2^14, so wrap past 14'h3FFF is silent. Counters are max(1,$clog2(N)) bits.
- start is ignored in RD, WR and DONE. No queueing.
- Overlapping SRC and DST windows are not protected. Result is defined by strict RD/WR element order.
- Reset at any point: state becomes IDLE, counters and hold clear, all outputs 0. The interrupted transfer is abandoned with no done pulse.

## Timing
- All outputs are registered. Reset values: per_addr=0, per_din=0, per_en=0, per_we=0, busy=0, done=0.
- Let start be sampled high at edge T0.
  - First RD cycle is T0→T1. First WR cycle is T1→T2.
  - Element k (0-based, row-major) occupies RD at cycle 2k and WR at cycle 2k+1.
  - done is high in cycle 2N², i.e. 2N²+1 cycles after start.
- Exactly one bus cycle per clock. per_en is never low between consecutive RD/WR cycles of one transfer.
- start asserted in the DONE cycle is ignored. start in the cycle after DONE is accepted.
- Minimum restart gap: one IDLE cycle.

## Structure
- Shared package per_bus_pkg:
  - state enum {IDLE, RD, WR, DONE};
  - constants PER_WE_READ=2'b00 and PER_WE_WORD=2'b11;
  - 14-bit address typedef.
- Sub-module per_idx_counter holds the nested r/c counter. Ports: clr, inc, r, c, last (r==N-1 && c==N-1), parameter N. It is reused by later scatter/gather masters.

## Test plan
- N=2, SRC_BASE=0x088, DST_BASE=0x090, slave RAM with 0x088..0x08B = 1,2,3,4. Pulse start → writes 0x090=1, 0x092=2, 0x091=3, 0x093=4. done is high exactly in cycle 8 after start; busy is high for cycles 0..7.
- N=4, source = 0x0100+k. Destination word at DST_BASE+c*4+r equals 0x0100+r*4+c for all 16 elements. Bus trace strictly alternates per_we 00/11.
- start pulsed again in cycle 3 of a transfer → no effect on the trace; a single done pulse.
- puc_rst asserted asynchronously mid-transfer (during a WR) → all outputs 0 immediately, no done. A new start afterwards runs a complete, correct transfer from element (0,0).
- N=1 → one read of SRC_BASE and one write to DST_BASE; done in cycle 2.
- SRC_BASE=14'h3FFE, N=2 → reads addresses 3FFE, 3FFF, 0000, 0001 in that order (wrap).
